aes_round_seq: RTL and testbench

Parametrised iterative round sequencer for the AES encryption path. It replaces the fixed 10-round, free-running round controller with a valid/ready-handshaked engine. It supports any round count (AES-128/192/256 via NR and KEY_W), a backpressured output, and round-index/last-round signalling to an external combinational round datapath. It sits between the block-input staging logic and the ciphertext consumer, and owns the state and round-key registers.

---
 rtl/aes_round_seq.sv | 143 ++++++++++++++
 tb/tb_aes_round_seq.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_seq.sv
// aes_round_seq
// Iterative AES encryption round sequencer with valid/ready handshakes.
// It owns the state and key registers and drives an external combinational
// round datapath through rf_state/rf_key/rf_round/rf_last, taking back the
// next state (rf_out) and next key material (rf_exkey) once per round.
//
// Optional feature: define AES_SEQ_ABORT_EN to add an 'abort' input.
// Abort returns the sequencer to IDLE from RUN or DONE and blocks
// acceptance while in IDLE.
module aes_round_seq #(
    parameter int DATA_W = 128,
    parameter int KEY_W  = 128,
    parameter int NR     = 10,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef AES_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEY_W-1:0]  in_key,
    output logic [DATA_W-1:0] rf_state,
    output logic [KEY_W-1:0]  rf_key,
    output logic [CNT_W-1:0]  rf_round,
    output logic              rf_last,
    input  logic [DATA_W-1:0] rf_out,
    input  logic [KEY_W-1:0]  rf_exkey,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Final round index, sized to the counter.
    localparam logic [CNT_W-1:0] C_NR  = CNT_W'(NR);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    state_t              r_fsm;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_state;
    logic [KEY_W-1:0]    r_key;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;

    logic                w_abort;
    logic                w_in_run;
    logic                w_last;
    logic                w_accept;
    logic [DATA_W-1:0]   w_init_state;

`ifdef AES_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Initial AddRoundKey uses the most significant DATA_W bits of the key,
    // which is the first round key for every AES key size.
    assign w_init_state = in_data ^ in_key[KEY_W-1 -: DATA_W];

    assign w_in_run  = (r_fsm == S_RUN);
    assign w_last    = w_in_run && (r_cnt == C_NR);
    assign w_accept  = (r_fsm == S_IDLE) && in_valid && !w_abort;

    // Datapath-facing and handshake outputs.
    assign in_ready  = (r_fsm == S_IDLE);
    assign busy      = (r_fsm != S_IDLE);
    assign rf_state  = r_state;
    assign rf_key    = r_key;
    assign rf_round  = w_in_run ? r_cnt : '0;
    assign rf_last   = w_last;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Sequencer FSM: accept a block, step NR rounds, then hold the result
    // until the consumer takes it (or an abort discards it).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm       <= S_IDLE;
            r_cnt       <= '0;
            r_state     <= '0;
            r_key       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= w_init_state;
                        r_key   <= in_key;
                        r_cnt   <= C_ONE;
                        r_fsm   <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (w_abort) begin
                        // Registers keep their contents; only control resets.
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                        r_fsm       <= S_IDLE;
                    end else begin
                        r_state <= rf_out;
                        r_key   <= rf_exkey;
                        if (w_last) begin
                            r_out_data  <= rf_out;
                            r_out_valid <= 1'b1;
                            r_cnt       <= '0;
                            r_fsm       <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + C_ONE;
                        end
                    end
                end

                S_DONE: begin
                    // Abort takes priority: the held output is dropped.
                    if (w_abort || out_ready) begin
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_fsm       <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_cnt       <= '0;
                    r_fsm       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_seq.sv
// tb_aes_round_seq
// Directed bench for aes_round_seq. Two instances: AES-128 (NR=10) and
// AES-256 (KEY_W=256, NR=14). The round datapath is modelled here from the
// AES definition (S-box by GF(2^8) inversion + affine map, ShiftRows,
// MixColumns, key schedule). Instance A can also be switched to a trivial
// stub datapath (state + round index) for latency and rf_last checks.
module tb_aes_round_seq;

    logic clk;
    logic reset;
`ifdef AES_SEQ_ABORT_EN
    logic abort;
`endif

    int n_checks;
    int n_pass;

    // ---------------- instance A: AES-128 ----------------
    logic         a_in_valid, a_in_ready, a_rf_last, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_data, a_in_key, a_rf_state, a_rf_key, a_rf_out, a_rf_exkey, a_out_data;
    logic [3:0]   a_rf_round;
    logic         stub_mode;

    // ---------------- instance B: AES-256 ----------------
    logic         b_in_valid, b_in_ready, b_rf_last, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_data, b_rf_state, b_rf_out, b_out_data;
    logic [255:0] b_in_key, b_rf_key, b_rf_exkey;
    logic [3:0]   b_rf_round;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_round_seq #(.DATA_W(128), .KEY_W(128), .NR(10), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset),
`ifdef AES_SEQ_ABORT_EN
        .abort(abort),
`endif
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_key(a_in_key),
        .rf_state(a_rf_state), .rf_key(a_rf_key), .rf_round(a_rf_round), .rf_last(a_rf_last),
        .rf_out(a_rf_out), .rf_exkey(a_rf_exkey),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
    );

    aes_round_seq #(.DATA_W(128), .KEY_W(256), .NR(14), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset),
`ifdef AES_SEQ_ABORT_EN
        .abort(abort),
`endif
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_key(b_in_key),
        .rf_state(b_rf_state), .rf_key(b_rf_key), .rf_round(b_rf_round), .rf_last(b_rf_last),
        .rf_out(b_rf_out), .rf_exkey(b_rf_exkey),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES reference functions ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p, r;
        p = a; r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] c;
        c = 8'h01;
        for (int i = 1; i < n; i++) c = gmul(c, 8'h02);
        return c;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // SubBytes, ShiftRows and (unless last) MixColumns; no key addition.
    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) sb[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[r+4*c] = sb[r + 4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {
                    gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                    a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                    a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                    gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
            end
        end
        return o;
    endfunction

    // AES-128: next round key from the previous one.
    function automatic logic [127:0] key_exp128(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word(rot_word(k[31:0])) ^ {rcon(int'(rnd)), 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // AES-256: slide an 8-word window forward by four words.
    function automatic logic [255:0] key_exp256(input logic [255:0] k, input logic [3:0] rnd);
        logic [31:0] t, n0, n1, n2, n3;
        if (rnd[0]) t = sub_word(rot_word(k[31:0])) ^ {rcon((int'(rnd) + 1) / 2), 24'h0};
        else        t = sub_word(k[31:0]);
        n0 = k[255:224] ^ t;
        n1 = k[223:192] ^ n0;
        n2 = k[191:160] ^ n1;
        n3 = k[159:128] ^ n2;
        return {k[127:0], n0, n1, n2, n3};
    endfunction

    // Combinational datapath for instance A (stub or real AES-128 round).
    always_comb begin
        a_rf_out   = '0;
        a_rf_exkey = '0;
        if (stub_mode) begin
            a_rf_out   = a_rf_state + {124'h0, a_rf_round};
            a_rf_exkey = a_rf_key;
        end else begin
            a_rf_exkey = key_exp128(a_rf_key, a_rf_round);
            a_rf_out   = aes_round(a_rf_state, a_rf_last) ^ a_rf_exkey;
        end
    end

    // Combinational datapath for instance B (AES-256 round).
    always_comb begin
        b_rf_exkey = key_exp256(b_rf_key, b_rf_round);
        b_rf_out   = aes_round(b_rf_state, b_rf_last) ^ b_rf_key[127:0];
    end

    // ---------------- bench helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic a_send(input logic [127:0] d, input logic [127:0] k);
        a_in_data  = d;
        a_in_key   = k;
        a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; lat counts edges after the accept edge.
    task automatic a_wait_out(output int lat);
        lat = 0;
        while (!a_out_valid && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic a_consume;
        a_out_ready = 1'b1;
        tick;
        a_out_ready = 1'b0;
    endtask

    int lat, last_cnt, last_at, seen, acc, cyc;
    int acc_at [2];

    initial begin
        n_checks = 0; n_pass = 0;
        reset = 1'b0;
`ifdef AES_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        stub_mode  = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_key = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_key = '0; b_out_ready = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  256'(a_in_ready), 256'd1);
        check("rst_busy",      256'(a_busy), 256'd0);
        check("rst_out_valid", 256'(a_out_valid), 256'd0);
        check("rst_out_data",  256'(a_out_data), 256'd0);
        check("rst_rf_round",  256'(a_rf_round), 256'd0);
        check("rst_rf_last",   256'(a_rf_last), 256'd0);
        check("rst_rf_key",    256'(a_rf_key), 256'd0);
        reset = 1'b1;
        tick;

        // ---- stub datapath: latency, rf_last, sum of round indices ----
        a_send('0, '0);
        check("stub_round1", 256'(a_rf_round), 256'd1);
        lat = 0; last_cnt = 0; last_at = 0;
        while (!a_out_valid && lat < 40) begin
            if (a_rf_last) begin
                last_cnt++;
                last_at = lat + 1;
            end
            tick;
            lat++;
        end
        $display("blk stub: out_data=%h lat=%0d", a_out_data, lat);
        check("stub_latency",   256'(lat), 256'd10);
        check("stub_last_once", 256'(last_cnt), 256'd1);
        check("stub_last_at",   256'(last_at), 256'd10);
        check("stub_out_data",  256'(a_out_data), 256'h37);
        check("stub_done_rdy",  256'(a_in_ready), 256'd0);
        a_consume;
        check("stub_after_ov",  256'(a_out_valid), 256'd0);
        check("stub_after_rdy", 256'(a_in_ready), 256'd1);

        // ---- FIPS-197 AES-128 with 5 cycles of backpressure ----
        stub_mode = 1'b0;
        a_send(PT, K128);
        a_wait_out(lat);
        $display("blk aes128: out_data=%h lat=%0d", a_out_data, lat);
        check("aes128_latency", 256'(lat), 256'd10);
        check("aes128_data",    256'(a_out_data), 256'(CT128));
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp_data",  256'(a_out_data), 256'(CT128));
            check("bp_valid", 256'(a_out_valid), 256'd1);
            check("bp_ready", 256'(a_in_ready), 256'd0);
        end
        a_consume;
        check("bp_release_rdy", 256'(a_in_ready), 256'd1);
        check("bp_release_ov",  256'(a_out_valid), 256'd0);

        // ---- back-to-back blocks with out_ready held high ----
        a_in_data = PT; a_in_key = K128; a_in_valid = 1'b1; a_out_ready = 1'b1;
        acc = 0; cyc = 0; acc_at[0] = 0; acc_at[1] = 0;
        while (acc < 2 && cyc < 100) begin
            if (a_in_ready) begin
                acc_at[acc] = cyc;
                acc++;
            end
            tick;
            cyc++;
        end
        a_in_valid = 1'b0;
        check("b2b_spacing", 256'(acc_at[1] - acc_at[0]), 256'd12);
        a_out_ready = 1'b0;
        a_wait_out(lat);
        $display("blk b2b: out_data=%h lat=%0d", a_out_data, lat);
        check("b2b_data", 256'(a_out_data), 256'(CT128));
        a_consume;

        // ---- asynchronous reset at round 4 ----
        a_send(PT, K128);
        repeat (3) tick;
        check("rst4_round", 256'(a_rf_round), 256'd4);
        reset = 1'b0;
        #1;
        check("rst4_busy",  256'(a_busy), 256'd0);
        check("rst4_rdy",   256'(a_in_ready), 256'd1);
        check("rst4_round0", 256'(a_rf_round), 256'd0);
        check("rst4_ov",    256'(a_out_valid), 256'd0);
        tick;
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (a_out_valid) seen++;
        end
        check("rst4_no_stale_ov", 256'(seen), 256'd0);
        check("rst4_rdy_after",   256'(a_in_ready), 256'd1);

        // ---- in_valid toggling with new data during RUN is ignored ----
        a_send(PT, K128);
        lat = 0;
        while (!a_out_valid && lat < 40) begin
            a_in_valid = 1'($urandom_range(0, 1));
            a_in_data  = {$urandom, $urandom, $urandom, $urandom};
            a_in_key   = {$urandom, $urandom, $urandom, $urandom};
            tick;
            lat++;
        end
        a_in_valid = 1'b0;
        $display("blk toggle: out_data=%h lat=%0d", a_out_data, lat);
        check("toggle_latency", 256'(lat), 256'd10);
        check("toggle_data",    256'(a_out_data), 256'(CT128));
        a_consume;

        // ---- FIPS-197 AES-256, NR=14 ----
        b_in_data = PT; b_in_key = K256; b_in_valid = 1'b1;
        tick;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 40) begin
            tick;
            lat++;
        end
        $display("blk aes256: out_data=%h lat=%0d", b_out_data, lat);
        check("aes256_latency", 256'(lat), 256'd14);
        check("aes256_data",    256'(b_out_data), 256'(CT256));
        b_out_ready = 1'b1;
        tick;
        b_out_ready = 1'b0;
        check("aes256_rdy", 256'(b_in_ready), 256'd1);

`ifdef AES_SEQ_ABORT_EN
        // ---- abort at round 3 ----
        a_send(PT, K128);
        repeat (2) tick;
        check("abort_round3", 256'(a_rf_round), 256'd3);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_idle_busy", 256'(a_busy), 256'd0);
        check("abort_idle_rdy",  256'(a_in_ready), 256'd1);
        check("abort_round0",    256'(a_rf_round), 256'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (a_out_valid) seen++;
        end
        check("abort_no_ov", 256'(seen), 256'd0);
        // abort in IDLE wins over in_valid
        a_in_data = PT; a_in_key = K128; a_in_valid = 1'b1; abort = 1'b1;
        tick;
        a_in_valid = 1'b0; abort = 1'b0;
        check("abort_blocks_accept", 256'(a_busy), 256'd0);
        // abort in DONE wins over out_ready
        a_send(PT, K128);
        a_wait_out(lat);
        check("abort_done_ov", 256'(a_out_valid), 256'd1);
        abort = 1'b1; a_out_ready = 1'b1;
        tick;
        abort = 1'b0; a_out_ready = 1'b0;
        check("abort_done_drop", 256'(a_out_valid), 256'd0);
        check("abort_done_hold", 256'(a_out_data), 256'(CT128));
        // a fresh block after abort
        a_send(PT, K128);
        a_wait_out(lat);
        $display("blk post_abort: out_data=%h lat=%0d", a_out_data, lat);
        check("abort_next_lat",  256'(lat), 256'd10);
        check("abort_next_data", 256'(a_out_data), 256'(CT128));
        a_consume;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
